// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: fetch PC, memory req/ack handshake,
// a small prefetch FIFO of {pc, word} pairs, and single-cycle redirect.
module instr_fetch_unit #(
    parameter int unsigned          DataWidth   = 32,
    parameter int unsigned          AddrWidth   = 24,
    parameter int unsigned          FifoDepth   = 2,
    parameter logic [AddrWidth-1:0] ResetVector = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          FetchEn,
    input  logic                          IRReady,
    input  logic                          Redirect,
    input  logic [AddrWidth-1:0]          RedirectAddr,
    input  logic                          MemAck,
    input  logic [DataWidth-1:0]          MemDataIn,
    output logic                          MemRdReq,
    output logic [AddrWidth-1:0]          MemAddr,
    output logic                          IRInEn,
    output logic [DataWidth-1:0]          IRDataOut,
    output logic [AddrWidth-1:0]          InstrPC,
    output logic [$clog2(FifoDepth):0]    FifoCount
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(FifoDepth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   pc_q, pc_d;
    logic [AddrWidth-1:0]   mem_addr_q, mem_addr_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [DataWidth-1:0]   fifo_data_q [FifoDepth];
    logic [AddrWidth-1:0]   fifo_pc_q   [FifoDepth];

    logic                   push;
    logic                   pop;
    logic                   room_after;

    // Handshake and delivery decode from registered state
    assign MemRdReq  = (state_q == REQ) || (state_q == FLUSH);
    assign MemAddr   = mem_addr_q;
    assign FifoCount = count_q;
    assign IRDataOut = fifo_data_q[rd_ptr_q];
    assign InstrPC   = fifo_pc_q[rd_ptr_q];
    assign pop       = (count_q != '0) && IRReady && !Redirect;
    assign IRInEn    = pop;
    assign push      = (state_q == REQ) && MemAck && !Redirect;

    // FIFO pointer/count update; redirect empties the buffer
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Capacity after this edge, used to decide back-to-back requests
    assign room_after = (count_d < DepthC);

    // Next-state, fetch PC and request address
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (Redirect) begin
                    pc_d    = RedirectAddr;
                    state_d = FetchEn ? REQ : IDLE;
                end else if (FetchEn && (count_q < DepthC)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (Redirect) begin
                    pc_d = RedirectAddr;
                    if (MemAck) begin
                        state_d = FetchEn ? REQ : IDLE;
                    end else begin
                        state_d = FLUSH;
                    end
                end else if (MemAck) begin
                    pc_d    = pc_q + AddrWidth'(1);
                    state_d = (FetchEn && room_after) ? REQ : IDLE;
                end
            end
            FLUSH: begin
                if (Redirect) begin
                    pc_d = RedirectAddr;
                end
                if (MemAck) begin
                    state_d = FetchEn ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A discarded request keeps its original address on the bus
        mem_addr_d = (state_d == FLUSH) ? mem_addr_q : pc_d;
    end

    // State, PC and FIFO control registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= ResetVector;
            mem_addr_q <= ResetVector;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage: each entry pairs the returned word with its address
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else if (push) begin
            fifo_data_q[wr_ptr_q] <= MemDataIn;
            fifo_pc_q[wr_ptr_q]   <= mem_addr_q;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch sequencer that produces the instruction stream consumed by the instruction register.
- Holds the fetch PC and issues word reads to memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO.
- Delivers one instruction per IRInEn pulse, with the matching PC, when the controller is ready.
- Supports a single-cycle redirect (branch/jump) that flushes in-flight and buffered fetches.

Parameters:
DataWidth, 32, instruction word width (opcode [31:24], operand [23:0])
AddrWidth, 24, word address width; fetch PC wraps modulo 2^AddrWidth
FifoDepth, 2, prefetch buffer entries (power of 2, >=2)
ResetVector, 24'h000000, fetch PC loaded at reset

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high
FetchEn  in  1  controller permits new memory requests
IRReady  in  1  controller can accept an instruction this cycle
Redirect  in  1  one-cycle pulse: restart fetch at RedirectAddr
RedirectAddr  in  AddrWidth  new fetch address
MemAck  in  1  memory read complete; MemDataIn valid this cycle
MemDataIn  in  DataWidth  read data
MemRdReq  out  1  read request, held until MemAck
MemAddr  out  AddrWidth  read address, stable while MemRdReq=1
IRInEn  out  1  IRDataOut/InstrPC valid and consumed this cycle
IRDataOut  out  DataWidth  FIFO head instruction word
InstrPC  out  AddrWidth  address of FIFO head instruction
FifoCount  out  clog2(FifoDepth)+1  entries currently buffered

Behaviour:
Reset (async):
- state=IDLE, fetch PC=ResetVector, FIFO empty.
- MemRdReq=0, MemAddr=ResetVector, IRInEn=0, IRDataOut=0, InstrPC=0, FifoCount=0.

FSM states: IDLE, REQ, FLUSH. MemRdReq = (state==REQ || state==FLUSH), registered state decode. MemAddr = fetch PC register.

Room condition: room = (FifoCount + (state==REQ ? 1 : 0)) < FifoDepth. Outstanding request counts against capacity; FIFO never overflows.

IDLE:
- FetchEn & room & !Redirect -> REQ. MemRdReq rises the cycle after the decision edge.

REQ:
- MemAck=0: hold MemAddr and MemRdReq.
- MemAck=1: push {MemAddr, MemDataIn}; fetch PC <= PC+1, wrapping 2^AddrWidth-1 -> 0.
- On ack, next state is REQ if FetchEn & room (evaluated with the push counted), else IDLE.
- Zero-wait memory with continuous ack sustains 1 word/cycle.

FLUSH:
- Request outstanding at redirect; hold the old address and MemRdReq until MemAck.
- Discard the returned data (no push).
- Next state: REQ if FetchEn, else IDLE. Fetch PC already holds RedirectAddr.

Delivery:
- IRInEn = FIFO non-empty & IRReady & !Redirect (combinational).
- IRDataOut/InstrPC always show the head entry (0 when empty after reset; last values otherwise).
- Pop on rising edge when IRInEn=1.
- Push and pop in the same cycle are legal; FifoCount is unchanged.
- Latency: MemAck in cycle N -> IRInEn can assert in cycle N+1.

Redirect (priority over everything except reset):
- At the edge: FIFO cleared, fetch PC <= RedirectAddr, IRInEn=0 that cycle.
- State REQ & MemAck=0 -> FLUSH.
- State REQ & MemAck=1 -> data discarded; next state REQ if FetchEn, else IDLE.
- State IDLE -> REQ if FetchEn, else IDLE.
- Redirect while in FLUSH: update fetch PC, stay in FLUSH.

Other rules:
- FetchEn deasserted mid-REQ does not abort the request; it completes, then goes to IDLE.
- Memory must not assert MemAck while MemRdReq=0; such an ack is ignored.

Test Plan:
1. Reset, hold FetchEn=0 -> all outputs 0/ResetVector, MemRdReq stays 0 for 10 cycles.
2. FetchEn=1, IRReady=1, MemAck=1 every requested cycle, memory word = 0xA0000000|addr -> IRInEn every cycle from cycle 3; InstrPC 0,1,2,... and IRDataOut 0xA0000000, 0xA0000001, ...
3. IRReady=0, zero-wait memory -> exactly 2 pushes (FifoCount=2), MemRdReq drops to 0. IRReady=1 for one cycle -> one pop, one new request at next PC.
4. Memory with 3 wait states; Redirect to 0x000100 in 2nd wait cycle -> FLUSH holds old MemAddr until ack, data discarded, next MemAddr=0x000100, first IRInEn has InstrPC=0x000100.
5. Redirect to 0xFFFFFE with continuous fetch -> InstrPC sequence 0xFFFFFE, 0xFFFFFF, 0x000000.
6. Assert reset mid-REQ with FIFO holding 1 entry -> MemRdReq=0, FifoCount=0, IRInEn=0 immediately (asynchronously); fetch resumes at ResetVector after release.
